sign_text_emitter: RTL
======================

// Module: sign_text_emitter
// PURPOSE
//  Downstream of the sign-to-text pipeline. Consumes the per-frame 4-bit sign code and
//  debounces it across frames: a code must persist for STABLE_FRAMES frames before it counts.
//  Maps each accepted code to an ASCII character and buffers it in a small FIFO.
//  Presents the characters on a valid/ready byte stream for the text/UART sink.
// PARAMETERS
//  STABLE_FRAMES  4  consecutive identical frames required to accept a code (1..255)
//  FIFO_DEPTH     8  character FIFO entries; power of two, >=2
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous, active-high reset
//  sign_value   in   4  sign code from sign identification, sampled only on frame_done
//  frame_done   in   1  1-cycle pulse: sign_value is final for the frame just ended
//  char_ready   in   1  sink accepts char_data this cycle
//  char_valid   out  1  char_data holds the FIFO head
//  char_data    out  8  ASCII character
//  stable_sign  out  4  last accepted code (0 = no hand)
//  fifo_count   out  $clog2(FIFO_DEPTH)+1  occupancy
//  overflow     out  1  sticky: a character was dropped because the FIFO was full
// BEHAVIOUR
//  Reset: char_valid=0, char_data=8'h00, stable_sign=0, fifo_count=0, overflow=0.
//   FSM=IDLE, cand=0, run=0, FIFO empty. Reset mid-stream discards the FIFO and any partial run.
//  Code map (package LUT):
//   0 -> no hand, no char
//   1..10 -> '0'..'9' (8'h30..8'h39)
//   11 -> ' ' (8'h20)
//   12 -> CR (8'h0D)
//   13..15 -> invalid
//  Debounce, evaluated only in cycles with frame_done=1:
//   code==cand: run<=sat(run+1, 255); else cand<=code, run<=1.
//   "Complete" means the post-update run==STABLE_FRAMES.
//  FSM (registered):
//   IDLE:
//    - any frame -> COUNT.
//   COUNT:
//    - on complete with code 0: stable_sign<=0, -> IDLE, no push.
//    - on complete with code 13..15: -> LOCKED, stable_sign unchanged, no push.
//    - on complete with code 1..12: stable_sign<=code, push LUT[code], -> LOCKED.
//   LOCKED:
//    - frame with code!=cand -> COUNT (run restarts at 1).
//    - same code -> stay, never re-push.
//    - A letter repeats only after a different code (e.g. 0) has intervened, even for 1 frame.
//  Timing: the frame_done edge that completes the run registers the push request.
//   The push is written at the next edge; char_valid=1 in the cycle after that.
//   The char is visible 2 clocks after the completing frame_done edge.
//  FIFO:
//   - First-word-fall-through.
//   - Pop on char_valid&&char_ready.
//   - char_data is stable while char_valid&&!char_ready.
//   - Push when full with no pop that cycle: char dropped, overflow<=1 until rst.
//   - Push+pop the same cycle when full: both occur, count unchanged, no overflow.
//   - Push+pop on empty is not possible: FWFT gives one cycle of latency.
//   - Pointers wrap modulo FIFO_DEPTH; one extra count bit distinguishes full from empty.
//  frame_done pulses that arrive while the push is pending are still processed; pushes queue in order.
// STRUCTURE
//  sign_text_pkg:
//   - SIGN_NONE=4'd0, SIGN_SPACE=4'd11, SIGN_CR=4'd12
//   - function sign_to_ascii(4b)->8b, with an invalid flag
//   - FSM state enum {IDLE, COUNT, LOCKED}
//  Sub-module char_fifo (DEPTH, WIDTH=8): FWFT sync FIFO with push/pop/full/empty/count.
//  Top level holds the debounce FSM and the push/overflow logic.
// TESTING
//  1. STABLE_FRAMES=4, code 3 held 4 frames -> one push, char_data=8'h32 valid 2 clk after 4th frame_done; stable_sign=3.
//  2. Code 3 for 10 frames -> exactly one '2'; then 0 x1, then 3 x4 -> second '2' emitted.
//  3. Pattern 5,5,5,7,5,5,5 -> no char (run broken); 7 x4 -> '6'.
//  4. char_ready=0, emit 9 chars with FIFO_DEPTH=8 -> fifo_count=8, 9th dropped, overflow=1.
//     Drain -> 8 chars in order; overflow stays 1.
//  5. FIFO full with char_ready=1 on the push cycle -> no drop, count stays 8, overflow=0.
//  6. Codes 14 x4 -> no char, stable_sign unchanged. Assert rst mid-run -> all outputs at reset values.
//     Next run needs the full 4 frames.

Source files
------------

// File: rtl/sign_text_pkg.sv
// Shared definitions for the sign-to-text emitter: sign codes, ASCII map, FSM states.
package sign_text_pkg;

  localparam logic [3:0] SIGN_NONE  = 4'd0;
  localparam logic [3:0] SIGN_SPACE = 4'd11;
  localparam logic [3:0] SIGN_CR    = 4'd12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    LOCKED = 2'd2
  } emit_state_t;

  typedef struct packed {
    logic       invalid;
    logic [7:0] ch;
  } sign_char_t;

  // Code 0 maps to no character; 13..15 are flagged invalid.
  function automatic sign_char_t sign_to_ascii(input logic [3:0] code);
    sign_char_t r;
    r.invalid = 1'b0;
    r.ch      = 8'h00;
    if (code >= 4'd1 && code <= 4'd10) begin
      r.ch = 8'h2F + {4'h0, code};
    end else if (code == SIGN_SPACE) begin
      r.ch = 8'h20;
    end else if (code == SIGN_CR) begin
      r.ch = 8'h0D;
    end else if (code != SIGN_NONE) begin
      r.invalid = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sign_text_emitter_char_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is ignored
// unless a pop frees a slot in the same cycle.
module char_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset since empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sign_text_emitter.sv
// Debounces per-frame sign codes, maps accepted codes to ASCII and streams them out.
//  state  | meaning
//  IDLE   | no hand shown (or just reset); next frame starts counting
//  COUNT  | building a run of identical codes toward acceptance
//  LOCKED | code accepted; waiting for a different code before re-arming
module sign_text_emitter
  import sign_text_pkg::*;
#(
  parameter int STABLE_FRAMES = 4,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    sign_value,
  input  logic                          frame_done,
  input  logic                          char_ready,
  output logic                          char_valid,
  output logic [7:0]                    char_data,
  output logic [3:0]                    stable_sign,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);
  emit_state_t state, state_next;
  logic [3:0]  cand;
  logic [7:0]  run, run_next;
  logic        same, complete;
  logic [3:0]  stable_next;
  logic        push_req, push_next;
  logic [7:0]  push_data, push_data_next;
  logic        fifo_full, fifo_empty, pop;
  sign_char_t  lut;

  assign lut      = sign_to_ascii(sign_value);
  assign same     = (sign_value == cand);
  assign run_next = !same ? 8'd1 : (run == 8'hFF) ? 8'hFF : run + 8'd1;
  assign complete = (run_next == 8'(STABLE_FRAMES));

  // Next-state and acceptance decisions, only on frame boundaries.
  always_comb begin
    state_next     = state;
    stable_next    = stable_sign;
    push_next      = 1'b0;
    push_data_next = push_data;
    if (frame_done && (state != LOCKED || !same)) begin
      if (complete) begin
        if (sign_value == SIGN_NONE) begin
          stable_next = SIGN_NONE;
          state_next  = IDLE;
        end else if (lut.invalid) begin
          state_next  = LOCKED;
        end else begin
          stable_next    = sign_value;
          push_next      = 1'b1;
          push_data_next = lut.ch;
          state_next     = LOCKED;
        end
      end else begin
        state_next = COUNT;
      end
    end
  end

  // Debounce run, FSM state and registered push request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cand        <= SIGN_NONE;
      run         <= 8'd0;
      stable_sign <= SIGN_NONE;
      push_req    <= 1'b0;
      push_data   <= 8'h00;
    end else begin
      if (frame_done) begin
        cand <= sign_value;
        run  <= run_next;
      end
      state       <= state_next;
      stable_sign <= stable_next;
      push_req    <= push_next;
      push_data   <= push_data_next;
    end
  end

  assign char_valid = !fifo_empty;
  assign pop        = char_valid && char_ready;

  // Sticky flag for a character lost to a full FIFO with no simultaneous pop.
  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else if (push_req && fifo_full && !pop) overflow <= 1'b1;
  end

  char_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (push_data),
    .pop       (pop),
    .head      (char_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
